// File: rtl/frame_accumulator_if.sv
// Sample/result bundle for frame_accumulator.
// Purpose : carries the frame strobe, the incoming sample stream and the published
//           per-frame results between the sample datapath and the accumulator.
// Signals : adc_clock  - frame strobe (asynchronous to clk)
//           in_valid   - sample present this cycle
//           in_ch      - channel index of the sample
//           in_data    - signed sample
//           out_data   - published results, channel c at [c*OUT_W +: OUT_W]
//           out_valid  - one-cycle pulse when out_data updates
//           sample_cnt - accepted samples in the last published frame
//           busy       - a sample has been accepted since the last publish
//           ovf        - per-channel overflow flags (only with FRAME_ACC_OVF_FLAG_EN)
// Modports: master drives samples and observes results; slave is the accumulator.
interface frame_accumulator_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                       adc_clock;
    logic                       in_valid;
    logic [CH_W-1:0]            in_ch;
    logic signed [DATA_W-1:0]   in_data;
    logic [NUM_CH*OUT_W-1:0]    out_data;
    logic                       out_valid;
    logic [CNT_W-1:0]           sample_cnt;
    logic                       busy;
`ifdef FRAME_ACC_OVF_FLAG_EN
    logic [NUM_CH-1:0]          ovf;
`endif

    modport master (
        output adc_clock,
        output in_valid,
        output in_ch,
        output in_data,
        input  out_data,
        input  out_valid,
        input  sample_cnt,
`ifdef FRAME_ACC_OVF_FLAG_EN
        input  ovf,
`endif
        input  busy
    );

    modport slave (
        input  adc_clock,
        input  in_valid,
        input  in_ch,
        input  in_data,
        output out_data,
        output out_valid,
        output sample_cnt,
`ifdef FRAME_ACC_OVF_FLAG_EN
        output ovf,
`endif
        output busy
    );
endinterface

// File: rtl/frame_accumulator.sv
// Multi-channel signed frame accumulator.
// Purpose : sums signed samples per channel over one ADC frame. The rising edge of
//           adc_clock (synchronised into clk) ends the frame; the per-channel sums are
//           shifted, width-limited and published, and accumulation restarts.
// Ports   : clk    - system clock
//           rst_n  - asynchronous active-low reset
//           bus    - frame_accumulator_if slave (samples in, results out)
// Options : define FRAME_ACC_OVF_FLAG_EN to add per-channel sticky overflow flags
//           published on bus.ovf together with out_data.
module frame_accumulator #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned OUT_SHIFT = 0,
    parameter int unsigned SAT_EN    = 1,
    parameter int unsigned CNT_W     = 8
) (
    input logic              clk,
    input logic              rst_n,
    frame_accumulator_if.slave bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CH_W:0]      NUM_CH_L = NUM_CH[CH_W:0];
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [ACC_W-1:0]   ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]   ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]   OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    // Frame strobe synchroniser; r_sync[1] is the first metastability-safe stage.
    logic [2:0]             r_sync;
    logic                   w_tick;
    logic                   w_accept;
    logic signed [ACC_W:0]  w_sext;

    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_sample_cnt;
    logic                   r_out_valid;
    logic                   r_busy;

    logic [OUT_W-1:0]       w_ch_out [NUM_CH];

    assign w_tick   = r_sync[1] & ~r_sync[2];
    assign w_accept = bus.in_valid && ({1'b0, bus.in_ch} < NUM_CH_L);
    // One extra bit so the per-channel sum cannot overflow before the range check.
    assign w_sext   = {{(ACC_W + 1 - DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], bus.adc_clock};
        end
    end

    // Frame-level bookkeeping. A sample coincident with the tick opens the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_sample_cnt <= '0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_out_valid <= w_tick;
            if (w_tick) begin
                r_sample_cnt <= r_cnt;
                r_cnt        <= w_accept ? CNT_W'(1) : '0;
                r_busy       <= w_accept;
            end else if (w_accept) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_busy <= 1'b1;
            end
        end
    end

`ifdef FRAME_ACC_OVF_FLAG_EN
    logic w_ch_ovf [NUM_CH];
`endif

    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
        logic                    w_hit;
        logic signed [ACC_W:0]   w_sum;
        logic                    w_acc_ovf;
        logic [ACC_W-1:0]        w_acc_add;
        logic signed [ACC_W-1:0] w_shr;
        logic [ACC_W-OUT_W:0]    w_top;
        logic                    w_fits;
        logic [OUT_W-1:0]        w_lim;
        logic signed [ACC_W-1:0] r_acc;
        logic [OUT_W-1:0]        r_out;

        assign w_hit     = w_accept && ({1'b0, bus.in_ch} == (CH_W + 1)'(gc));
        assign w_sum     = {r_acc[ACC_W-1], r_acc} + w_sext;
        assign w_acc_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

        always_comb begin
            w_acc_add = w_sum[ACC_W-1:0];
            if ((SAT_EN != 0) && w_acc_ovf) begin
                w_acc_add = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end
        end

        // The shifted value fits OUT_W when all bits from OUT_W-1 upward agree.
        assign w_shr  = r_acc >>> OUT_SHIFT;
        assign w_top  = w_shr[ACC_W-1:OUT_W-1];
        assign w_fits = (&w_top) | ~(|w_top);

        always_comb begin
            w_lim = w_shr[OUT_W-1:0];
            if ((SAT_EN != 0) && !w_fits) begin
                w_lim = w_shr[ACC_W-1] ? OUT_MIN : OUT_MAX;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (w_tick) begin
                r_acc <= w_hit ? w_sext[ACC_W-1:0] : '0;
            end else if (w_hit) begin
                r_acc <= w_acc_add;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out <= '0;
            end else if (w_tick) begin
                r_out <= w_lim;
            end
        end

        assign w_ch_out[gc] = r_out;

`ifdef FRAME_ACC_OVF_FLAG_EN
        logic r_sticky;
        logic r_ovf;

        // A fresh accumulate from zero on the tick cannot overflow, so sticky just clears.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sticky <= 1'b0;
                r_ovf    <= 1'b0;
            end else if (w_tick) begin
                r_ovf    <= r_sticky | ~w_fits;
                r_sticky <= 1'b0;
            end else if (w_hit && w_acc_ovf) begin
                r_sticky <= 1'b1;
            end
        end

        assign w_ch_ovf[gc] = r_ovf;
`endif
    end

    always_comb begin
        bus.out_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.out_data[c*OUT_W +: OUT_W] = w_ch_out[c];
        end
    end

`ifdef FRAME_ACC_OVF_FLAG_EN
    always_comb begin
        bus.ovf = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.ovf[c] = w_ch_ovf[c];
        end
    end
`endif

    assign bus.out_valid  = r_out_valid;
    assign bus.sample_cnt = r_sample_cnt;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_frame_accumulator.sv
// Scoreboard bench for frame_accumulator: three differently configured instances share
// one stimulus stream; a frame-level reference model pushes expected publishes, and a
// monitor pops and compares on every out_valid.
module tb_frame_accumulator;
    localparam int NI = 3;
    // Instance configurations: A, B, C.
    localparam int P_NCH [NI] = '{2, 3, 2};
    localparam int P_CHW [NI] = '{1, 2, 1};
    localparam int P_ACC [NI] = '{24, 20, 18};
    localparam int P_SH  [NI] = '{0, 0, 2};
    localparam int P_SAT [NI] = '{1, 0, 1};
    localparam int P_CNT [NI] = '{8, 8, 3};

    typedef struct {
        logic [47:0] data;
        int          cnt;
        int          cyc;
        logic [2:0]  ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   edge_cnt;

    frame_accumulator_if #(.NUM_CH(2), .DATA_W(16), .OUT_W(16), .CNT_W(8)) if_a ();
    frame_accumulator_if #(.NUM_CH(3), .DATA_W(16), .OUT_W(16), .CNT_W(8)) if_b ();
    frame_accumulator_if #(.NUM_CH(2), .DATA_W(16), .OUT_W(16), .CNT_W(3)) if_c ();

    frame_accumulator #(.NUM_CH(2), .DATA_W(16), .ACC_W(24), .OUT_W(16), .OUT_SHIFT(0),
                        .SAT_EN(1), .CNT_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    frame_accumulator #(.NUM_CH(3), .DATA_W(16), .ACC_W(20), .OUT_W(16), .OUT_SHIFT(0),
                        .SAT_EN(0), .CNT_W(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    frame_accumulator #(.NUM_CH(2), .DATA_W(16), .ACC_W(18), .OUT_W(16), .OUT_SHIFT(2),
                        .SAT_EN(1), .CNT_W(3)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    logic [47:0] m_data  [NI];
    logic [7:0]  m_cnt   [NI];
    logic        m_valid [NI];
    logic        m_busy  [NI];
    logic [2:0]  m_ovf   [NI];

    assign m_data[0]  = {32'b0, if_a.out_data};
    assign m_data[1]  = if_b.out_data;
    assign m_data[2]  = {32'b0, if_c.out_data};
    assign m_cnt[0]   = if_a.sample_cnt;
    assign m_cnt[1]   = if_b.sample_cnt;
    assign m_cnt[2]   = {5'b0, if_c.sample_cnt};
    assign m_valid[0] = if_a.out_valid;
    assign m_valid[1] = if_b.out_valid;
    assign m_valid[2] = if_c.out_valid;
    assign m_busy[0]  = if_a.busy;
    assign m_busy[1]  = if_b.busy;
    assign m_busy[2]  = if_c.busy;
`ifdef FRAME_ACC_OVF_FLAG_EN
    assign m_ovf[0]   = {1'b0, if_a.ovf};
    assign m_ovf[1]   = if_b.ovf;
    assign m_ovf[2]   = {1'b0, if_c.ovf};
`else
    assign m_ovf[0]   = 3'b000;
    assign m_ovf[1]   = 3'b000;
    assign m_ovf[2]   = 3'b000;
`endif

    // Reference model state: exact per-channel frame sums and sticky overflow.
    longint m_acc [NI][3];
    bit     m_stk [NI][3];
    int     m_n   [NI];
    bit     exp_busy [NI];
    bit     hist [$];
    exp_t   sbq [NI][$];
    exp_t   mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Limit a value to w signed bits by clamping or two's-complement wrap.
    function automatic longint lim(input longint v, input int w, input int sat, output bit chg);
        longint mx;
        longint mn;
        longint m;
        longint r;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -(longint'(1) << (w - 1));
        m  = longint'(1) << w;
        if (sat != 0) begin
            r = (v > mx) ? mx : ((v < mn) ? mn : v);
        end else begin
            r = v & (m - 1);
            if (r > mx) r = r - m;
        end
        chg = (r != v);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 3; c++) begin
                m_acc[i][c] = 0;
                m_stk[i][c] = 0;
            end
            m_n[i]      = 0;
            exp_busy[i] = 0;
            sbq[i].delete();
        end
        hist.delete();
        repeat (3) hist.push_back(1'b0);
    endtask

    // One clock edge of the reference: the frame ends two edges after adc_clock is first
    // seen high; a sample on that edge already belongs to the next frame.
    task automatic model_edge(input bit v, input int ch, input int d, input bit adc, input int cyc);
        bit     tick;
        bit     chg;
        bit     acc;
        int     chi;
        longint r;
        exp_t   e;
        hist.push_back(adc);
        if (hist.size() > 4) void'(hist.pop_front());
        tick = hist[1] && !hist[0];
        for (int i = 0; i < NI; i++) begin
            chi = ch % (1 << P_CHW[i]);
            acc = v && (chi < P_NCH[i]);
            if (tick) begin
                e.data = '0;
                e.ovf  = '0;
                e.cnt  = m_n[i];
                e.cyc  = cyc;
                for (int c = 0; c < P_NCH[i]; c++) begin
                    r = lim(m_acc[i][c] >>> P_SH[i], 16, P_SAT[i], chg);
                    e.data = e.data | (48'(r & 64'hFFFF) << (c * 16));
                    e.ovf[c] = m_stk[i][c] | chg;
                    m_acc[i][c] = 0;
                    m_stk[i][c] = 0;
                end
                sbq[i].push_back(e);
                if (acc) m_acc[i][chi] = d;
                m_n[i]      = acc ? 1 : 0;
                exp_busy[i] = acc;
            end else if (acc) begin
                m_acc[i][chi] = lim(m_acc[i][chi] + d, P_ACC[i], P_SAT[i], chg);
                if (chg) m_stk[i][chi] = 1;
                if (m_n[i] < (1 << P_CNT[i]) - 1) m_n[i] = m_n[i] + 1;
                exp_busy[i] = 1;
            end
        end
    endtask

    task automatic drive(input bit v, input int ch, input int d, input bit adc);
        if_a.in_valid = v;  if_b.in_valid = v;  if_c.in_valid = v;
        if_a.in_ch = ch[0]; if_b.in_ch = ch[1:0]; if_c.in_ch = ch[0];
        if_a.in_data = 16'(d); if_b.in_data = 16'(d); if_c.in_data = 16'(d);
        if_a.adc_clock = adc; if_b.adc_clock = adc; if_c.adc_clock = adc;
    endtask

    task automatic step(input bit v, input int ch, input int d, input bit adc);
        @(negedge clk);
        drive(v, ch, d, adc);
        @(posedge clk);
        // edge_cnt updates via NBA, so this edge's index is edge_cnt + 1.
        model_edge(v, ch, d, adc, edge_cnt + 1);
    endtask

    task automatic frame_end();
        repeat (4) step(1'b0, 0, 0, 1'b1);
        repeat (2) step(1'b0, 0, 0, 1'b0);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 1'b0);
        model_clear();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                check($sformatf("inst%0d reset out_valid", i), m_valid[i], 0);
                check($sformatf("inst%0d reset out_data", i), m_data[i], 0);
                check($sformatf("inst%0d reset sample_cnt", i), m_cnt[i], 0);
                check($sformatf("inst%0d reset busy", i), m_busy[i], 0);
`ifdef FRAME_ACC_OVF_FLAG_EN
                check($sformatf("inst%0d reset ovf", i), m_ovf[i], 0);
`endif
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per out_valid and also flags missed publishes.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                if (sbq[i].size() > 0 && sbq[i][0].cyc < edge_cnt) begin
                    check($sformatf("inst%0d missed out_valid at edge", i), edge_cnt,
                          sbq[i][0].cyc);
                    void'(sbq[i].pop_front());
                end
                if (m_valid[i]) begin
                    check($sformatf("inst%0d out_valid expected", i), sbq[i].size() > 0, 1);
                    if (sbq[i].size() > 0) begin
                        mon_e = sbq[i].pop_front();
                        check($sformatf("inst%0d out_data", i), m_data[i], mon_e.data);
                        check($sformatf("inst%0d sample_cnt", i), m_cnt[i], mon_e.cnt);
                        check($sformatf("inst%0d publish edge", i), edge_cnt, mon_e.cyc);
`ifdef FRAME_ACC_OVF_FLAG_EN
                        check($sformatf("inst%0d ovf", i), m_ovf[i], mon_e.ovf);
`endif
                    end
                end
                check($sformatf("inst%0d busy", i), m_busy[i], exp_busy[i]);
            end
        end
    end

    initial begin
        int          len;
        int          hi;
        int          bias;
        int          d;
        logic signed [15:0] t16;
        tests    = 0;
        fails    = 0;
        edge_cnt = 0;
        rst_n    = 1'b0;
        drive(1'b0, 0, 0, 1'b0);
        model_clear();
        do_reset();

        // Basic frame.
        step(1'b1, 0, 100, 1'b0);
        step(1'b1, 0, 200, 1'b0);
        step(1'b1, 0, -50, 1'b0);
        step(1'b1, 1, 7, 1'b0);
        frame_end();
        check("A basic ch0", if_a.out_data[15:0], 250);
        check("A basic ch1", if_a.out_data[31:16], 7);
        check("A basic cnt", if_a.sample_cnt, 4);
        check("A basic busy after", if_a.busy, 0);

        // Output limiting: saturate vs truncate vs shifted.
        repeat (4) step(1'b1, 0, 30000, 1'b0);
        frame_end();
        check("A sat ch0", if_a.out_data[15:0], 16'h7FFF);
        check("B wrap ch0", if_b.out_data[15:0], 16'hD4C0);
        check("C shift ch0", if_c.out_data[15:0], 16'h7530);
        check("C cnt", if_c.sample_cnt, 4);
`ifdef FRAME_ACC_OVF_FLAG_EN
        check("A ovf", if_a.ovf, 2'b01);
`endif

        // Arithmetic shift floors negative sums.
        step(1'b1, 1, -8, 1'b0);
        step(1'b1, 1, -8, 1'b0);
        step(1'b1, 1, -1, 1'b0);
        frame_end();
        check("C shift ch1", if_c.out_data[31:16], 16'hFFFB);
        check("A ch1 neg", if_a.out_data[31:16], 16'hFFEF);

        // Sample coincident with the tick opens the next frame.
        step(1'b1, 0, 5, 1'b0);
        step(1'b1, 0, 5, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 0, 5, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        repeat (2) step(1'b0, 0, 0, 1'b0);
        #1;
        check("A coincident ch0", if_a.out_data[15:0], 10);
        check("A coincident cnt", if_a.sample_cnt, 2);
        check("A coincident busy", if_a.busy, 1);
        frame_end();
        check("A next ch0", if_a.out_data[15:0], 5);
        check("A next cnt", if_a.sample_cnt, 1);

        // Out-of-range channel is dropped.
        step(1'b1, 3, 1000, 1'b0);
        frame_end();
        check("B drop data", if_b.out_data, 0);
        check("B drop cnt", if_b.sample_cnt, 0);

        // Reset mid-frame discards the partial sum.
        step(1'b1, 0, 400, 1'b0);
        do_reset();
        frame_end();
        check("A post-reset data", if_a.out_data, 0);
        check("A post-reset cnt", if_a.sample_cnt, 0);

        // Randomised frames with biased bursts to push accumulators into overflow.
        for (int f = 0; f < 60; f++) begin
            len  = $urandom_range(80, 8);
            hi   = $urandom_range(6, 1);
            bias = $urandom_range(2, 0);
            for (int t = 0; t < len; t++) begin
                t16 = 16'($urandom);
                d = t16;
                if (bias == 1) d = $urandom_range(32767, 20000);
                if (bias == 2) d = -$urandom_range(32768, 20000);
                step(($urandom_range(3, 0) != 0), $urandom_range(3, 0), d, (t >= len - hi));
            end
        end
        repeat (5) step(1'b0, 0, 0, 1'b0);
        frame_end();
        repeat (3) step(1'b0, 0, 0, 1'b0);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("inst%0d pending publishes", i), sbq[i].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
